// File: rtl/sfp_mdio_master_multi.sv
// OPB-attached MDIO master driving Clause 22/45 frames onto one of
// C_NUM_CHAN management buses from a single shared frame engine.
module sfp_mdio_master_multi #(
  parameter logic [31:0] C_BASEADDR   = 32'h00060000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0006FFFF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_CHAN   = 4,
  parameter int          C_MDC_DIV    = 24
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic [C_NUM_CHAN-1:0]   mdc,
  output logic [C_NUM_CHAN-1:0]   mdio_o,
  output logic [C_NUM_CHAN-1:0]   mdio_t,
  input  logic [C_NUM_CHAN-1:0]   mdio_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_FRM
  } state_t;

  logic [31:0] w_abus;
  logic [31:0] w_dbus;
  logic [1:0]  w_off;
  logic        w_hit;
  logic        w_acc;
  logic        w_stat_rd;
  logic        w_cmd_wr;
  logic        w_cfg_wr;
  logic        w_cmd_bad;
  logic        w_ovr_set;
  logic        w_cherr_set;
  logic [31:0] w_rdmux;
  logic        w_c45;
  logic [1:0]  w_op;
  logic        w_wr;
  logic [31:0] w_frame;
  logic [7:0]  w_mdi;
  logic        w_unused;

  logic        r_ack;
  logic [31:0] r_dbus;
  logic [7:0]  r_div;
  logic        r_nopre;
  logic [31:0] r_cmd;
  logic        r_start;

  state_t      r_state;
  logic        r_busy;
  logic        r_done;
  logic        r_ovr;
  logic        r_cherr;
  logic [15:0] r_rdata;
  logic [15:0] r_rsh;
  logic [2:0]  r_chan;
  logic [7:0]  r_fdiv;
  logic [7:0]  r_cnt;
  logic [4:0]  r_bit;
  logic [31:0] r_frame;
  logic        r_rd;
  logic        r_mdc;
  logic        r_mdo;
  logic        r_mdt;

  assign w_abus = OPB_ABus;
  assign w_dbus = OPB_DBus;
  assign w_off  = w_abus[3:2];
  assign w_hit  = OPB_select
               && (w_abus >= C_BASEADDR)
               && (w_abus <= C_HIGHADDR);
  // One accept per two cycles: a held select is acked every other cycle.
  assign w_acc     = w_hit && !r_ack;
  assign w_stat_rd = w_acc && OPB_RNW && (w_off == 2'd1);
  assign w_cmd_wr  = w_acc && !OPB_RNW && (w_off == 2'd0);
  assign w_cfg_wr  = w_acc && !OPB_RNW && (w_off == 2'd2);
  assign w_cmd_bad = 32'(w_dbus[15:13]) >= 32'(C_NUM_CHAN);

  assign w_ovr_set   = w_cmd_wr && (r_busy || r_start);
  assign w_cherr_set = w_cmd_wr && !(r_busy || r_start)
                    && w_cmd_bad;

  assign w_unused = ^{OPB_BE, OPB_seqAddr};

  assign Sl_DBus    = r_dbus;
  assign Sl_xferAck = r_ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  always_comb begin
    w_rdmux = '0;
    case (w_off)
      2'd1: w_rdmux = {r_rdata, 12'd0,
                       r_cherr, r_ovr, r_done, r_busy};
      2'd2: w_rdmux = {23'd0, r_nopre, r_div};
      default: w_rdmux = '0;
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      r_ack   <= 1'b0;
      r_dbus  <= '0;
      r_div   <= 8'(C_MDC_DIV);
      r_nopre <= 1'b0;
      r_cmd   <= '0;
      r_start <= 1'b0;
    end else begin
      r_ack   <= w_acc;
      r_dbus  <= (w_acc && OPB_RNW) ? w_rdmux : '0;
      r_start <= w_cmd_wr && !(r_busy || r_start)
              && !w_cmd_bad;
      if (w_cmd_wr && !(r_busy || r_start))
        r_cmd <= w_dbus;
      if (w_cfg_wr) begin
        r_div   <= (w_dbus[7:0] == 8'd0) ? 8'd1
                                         : w_dbus[7:0];
        r_nopre <= w_dbus[8];
      end
    end
  end

  assign w_c45 = r_cmd[12];
  assign w_op  = r_cmd[11:10];
  assign w_wr  = w_c45 ? !w_op[1] : (w_op == 2'b01);
  // Read ops release the line for TA/DATA; the ones are never driven.
  assign w_frame = {w_c45 ? 2'b00 : 2'b01, w_op,
                    r_cmd[4:0], r_cmd[9:5],
                    w_wr ? 2'b10 : 2'b11,
                    w_wr ? r_cmd[31:16] : 16'hFFFF};

  always_comb begin
    w_mdi = '0;
    w_mdi[C_NUM_CHAN-1:0] = mdio_i;
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
      r_cherr <= 1'b0;
      r_rdata <= '0;
      r_rsh   <= '0;
      r_chan  <= '0;
      r_fdiv  <= 8'd1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_frame <= '0;
      r_rd    <= 1'b0;
      r_mdc   <= 1'b0;
      r_mdo   <= 1'b1;
      r_mdt   <= 1'b1;
    end else begin
      if (w_stat_rd) begin
        r_done  <= 1'b0;
        r_ovr   <= 1'b0;
        r_cherr <= 1'b0;
      end
      if (w_ovr_set)
        r_ovr <= 1'b1;
      if (w_cherr_set)
        r_cherr <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (r_start) begin
            r_chan  <= r_cmd[15:13];
            r_fdiv  <= r_div;
            r_frame <= w_frame;
            r_rd    <= !w_wr;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_mdc   <= 1'b0;
            r_mdt   <= 1'b0;
            if (r_nopre) begin
              r_state <= S_FRM;
              r_mdo   <= w_frame[31];
            end else begin
              r_state <= S_PRE;
              r_mdo   <= 1'b1;
            end
          end
        end
        default: begin
          if (r_cnt != r_fdiv) begin
            r_cnt <= r_cnt + 8'd1;
          end else if (!r_mdc) begin
            r_cnt <= '0;
            r_mdc <= 1'b1;
          end else begin
            r_cnt <= '0;
            r_mdc <= 1'b0;
            if (r_state == S_FRM && r_rd
                && r_bit >= 5'd16)
              r_rsh <= {r_rsh[14:0], w_mdi[r_chan]};
            if (r_bit == 5'd31) begin
              r_bit <= '0;
              if (r_state == S_PRE) begin
                r_state <= S_FRM;
                r_mdo   <= r_frame[31];
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_mdo   <= 1'b1;
                r_mdt   <= 1'b1;
                if (r_rd)
                  r_rdata <= {r_rsh[14:0], w_mdi[r_chan]};
              end
            end else begin
              r_bit <= r_bit + 5'd1;
              if (r_state == S_FRM) begin
                r_frame <= r_frame << 1;
                r_mdo   <= r_frame[30];
                r_mdt   <= r_rd && (r_bit >= 5'd13);
              end
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    mdc    = '0;
    mdio_o = '1;
    mdio_t = '1;
    for (int c = 0; c < C_NUM_CHAN; c++) begin
      if (r_chan == 3'(c)) begin
        mdc[c]    = r_mdc;
        mdio_o[c] = r_mdo;
        mdio_t[c] = r_mdt;
      end
    end
  end

endmodule
